axilite_cmd_sequencer: RTL and testbench
========================================

Name: axilite_cmd_sequencer

Overview:
Upstream feeder for the AXI-Lite master's backend (bk_*) interface. Buffers read/write commands from a valid/ready command port in a small FIFO. Issues them to the master strictly one at a time as single-cycle start pulses, waits for the matching done pulse, and returns read data on a valid/ready response port.

Parameters:
CMD_DEPTH, 4, command FIFO entries; power of 2, >= 2
CNT_W, $clog2(CMD_DEPTH)+1, width of cmd_count (derived localparam, not overridable)

Ports:
axi_aclk  in  1  clock; sole clock domain
axi_aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; equals !full
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  32  byte address
cmd_data  in  32  write data (ignored for reads)
cmd_strb  in  4  write strobes (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_data  out  32  read data (0 for write responses)
rsp_wr  out  1  response belongs to a write (only ever 1 with the optional feature)
bk_wstart  out  1  one-cycle write start pulse
bk_waddr  out  32  write address
bk_wdata  out  32  write data
bk_wstrb  out  4  write strobes
bk_wdone  in  1  write complete pulse
bk_rstart  out  1  one-cycle read start pulse
bk_raddr  out  32  read address
bk_rdata  in  32  read data; valid in the cycle bk_rdone is high
bk_rdone  in  1  read complete pulse
busy  out  1  high in any state other than IDLE
cmd_count  out  CNT_W  current FIFO occupancy

Behaviour:
- Reset values: every output is 0 (cmd_ready is 1 once out of reset). FIFO is flushed and the FSM enters IDLE. Reset asserted mid-transaction discards the in-flight command and any pending response; the master shares the same reset.
- FIFO push: cmd_valid && cmd_ready. Push while full is impossible because cmd_ready=0. There is no bypass: a command pushed in cycle t is first visible at the FIFO head in t+1.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE -> ISSUE when the FIFO is non-empty.
- ISSUE (exactly 1 cycle):
  - drive bk_wstart or bk_rstart high according to the head entry's cmd_wr, and pop the FIFO;
  - go to WAIT_DONE.
- bk_waddr/bk_wdata/bk_wstrb/bk_raddr are registered and loaded on entry to ISSUE. They hold until the next ISSUE; they are not zeroed between commands.
- WAIT_DONE:
  - a write waits for bk_wdone, a read waits for bk_rdone;
  - a done pulse of the wrong type is ignored.
  - On bk_rdone: capture bk_rdata into rsp_data, set rsp_wr=0, go to RESP.
  - On bk_wdone: go to IDLE (or RESP with the optional feature).
  - There is no timeout.
- RESP: rsp_valid=1, with rsp_data/rsp_wr held stable until rsp_ready. On the handshake cycle go to IDLE and drop rsp_valid the next cycle.
- A push in the same cycle as a pop changes occupancy by 0. Pointers wrap modulo CMD_DEPTH.
- Minimum command cadence: IDLE->ISSUE->WAIT_DONE->(RESP)->IDLE. Only one command is outstanding at the master at any time.
- Commands complete in FIFO order.

Optional Feature:
AXIL_CMD_WRESP_EN:
- Defined: bk_wdone moves the FSM to RESP with rsp_wr=1 and rsp_data=0. Every command therefore produces exactly one response.
- Undefined: writes produce no response and rsp_wr is tied to 0.

Decomposition:
- Package axilite_cmd_pkg holds:
  - typedef cmd_t (packed struct: wr, addr[31:0], data[31:0], strb[3:0]);
  - enum seq_state_t {IDLE, ISSUE, WAIT_DONE, RESP};
  - localparams AXIL_AW=32, AXIL_DW=32, AXIL_SW=4.
- One sub-module, axilite_cmd_fifo: synchronous FIFO of cmd_t, parameterised by depth. It exposes push/pop/full/empty/count.

Test Plan:
- Write 0x0000_1000 data 0xDEAD_BEEF strb 0xF, master model returning bk_wdone 3 cycles after start -> one bk_wstart pulse carrying those exact values; no rsp_valid; busy returns to 0.
- Read 0x0000_2004, model returns bk_rdata 0x1234_5678 with bk_rdone -> one bk_rstart pulse with bk_raddr=0x0000_2004; rsp_valid with rsp_data=0x1234_5678, rsp_wr=0.
- Push 5 back-to-back commands with bk_*done held off -> cmd_ready=0 once cmd_count=4 after the first pop (head in flight); all 5 are issued in order; start pulses never overlap.
- Read with rsp_ready low for 10 cycles -> rsp_valid and rsp_data stable throughout; the next FIFO command is not issued until the handshake.
- Inject bk_rdone while waiting for a write -> ignored; the FSM stays in WAIT_DONE until bk_wdone.
- Assert axi_aresetn=0 during WAIT_DONE with 2 queued commands -> all outputs 0, cmd_count=0; after release no stale command is issued.
- With AXIL_CMD_WRESP_EN: write completes -> rsp_valid with rsp_wr=1, rsp_data=0.

Source files
------------

// File: rtl/axilite_cmd_sequencer_pkg.sv
// Shared types for the AXI-Lite command sequencer: command record, FSM states and bus widths.
package axilite_cmd_pkg;

    localparam int AXIL_AW = 32;
    localparam int AXIL_DW = 32;
    localparam int AXIL_SW = 4;

    typedef struct packed {
        logic               wr;
        logic [AXIL_AW-1:0] addr;
        logic [AXIL_DW-1:0] data;
        logic [AXIL_SW-1:0] strb;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESP
    } seq_state_t;

endpackage

// File: rtl/axilite_cmd_sequencer_if.sv
// Command, response and backend (bk_*) signals of the command sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
interface axilite_cmd_sequencer_if;

    logic                             cmd_valid;
    logic                             cmd_ready;
    logic                             cmd_wr;
    logic [axilite_cmd_pkg::AXIL_AW-1:0] cmd_addr;
    logic [axilite_cmd_pkg::AXIL_DW-1:0] cmd_data;
    logic [axilite_cmd_pkg::AXIL_SW-1:0] cmd_strb;

    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [axilite_cmd_pkg::AXIL_DW-1:0] rsp_data;
    logic                             rsp_wr;

    logic                             bk_wstart;
    logic [axilite_cmd_pkg::AXIL_AW-1:0] bk_waddr;
    logic [axilite_cmd_pkg::AXIL_DW-1:0] bk_wdata;
    logic [axilite_cmd_pkg::AXIL_SW-1:0] bk_wstrb;
    logic                             bk_wdone;
    logic                             bk_rstart;
    logic [axilite_cmd_pkg::AXIL_AW-1:0] bk_raddr;
    logic [axilite_cmd_pkg::AXIL_DW-1:0] bk_rdata;
    logic                             bk_rdone;

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_data, cmd_strb,
        input  rsp_ready,
        input  bk_wdone, bk_rdata, bk_rdone,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_wr,
        output bk_wstart, bk_waddr, bk_wdata, bk_wstrb, bk_rstart, bk_raddr
    );

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_data, cmd_strb,
        output rsp_ready,
        output bk_wdone, bk_rdata, bk_rdone,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_wr,
        input  bk_wstart, bk_waddr, bk_wdata, bk_wstrb, bk_rstart, bk_raddr
    );

endinterface

// File: rtl/axilite_cmd_fifo.sv
// Synchronous FIFO of cmd_t entries; DEPTH must be a power of 2 so the pointers wrap naturally.
module axilite_cmd_fifo
    import axilite_cmd_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  cmd_t             push_data,
    input  logic             pop,
    output cmd_t             head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/axilite_cmd_sequencer.sv
// Buffers commands and issues them one at a time to the AXI-Lite master backend.
// Optional macro AXIL_CMD_WRESP_EN: writes also produce a response (rsp_wr=1, rsp_data=0).
module axilite_cmd_sequencer
    import axilite_cmd_pkg::*;
#(
    parameter  int CMD_DEPTH = 4,
    localparam int CNT_W     = $clog2(CMD_DEPTH) + 1
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    axilite_cmd_sequencer_if.slave bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       cmd_count
);

    cmd_t       push_cmd, fifo_head;
    logic       fifo_full, fifo_empty, fifo_push, fifo_pop;

    seq_state_t         state_q, state_d;
    logic               cur_wr_q, cur_wr_d;
    logic               wstart_q, wstart_d;
    logic               rstart_q, rstart_d;
    logic [AXIL_AW-1:0] waddr_q, waddr_d;
    logic [AXIL_DW-1:0] wdata_q, wdata_d;
    logic [AXIL_SW-1:0] wstrb_q, wstrb_d;
    logic [AXIL_AW-1:0] raddr_q, raddr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [AXIL_DW-1:0] rsp_data_q, rsp_data_d;
`ifdef AXIL_CMD_WRESP_EN
    logic               rsp_wr_q, rsp_wr_d;
`endif

    assign push_cmd  = '{wr: bus.cmd_wr, addr: bus.cmd_addr, data: bus.cmd_data, strb: bus.cmd_strb};
    assign fifo_push = bus.cmd_valid && bus.cmd_ready;
    assign fifo_pop  = (state_q == ISSUE);

    axilite_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (cmd_count)
    );

    // Ready is held low while in reset so every output reads 0 then.
    assign bus.cmd_ready = axi_aresetn && !fifo_full;
    assign bus.bk_wstart = wstart_q;
    assign bus.bk_rstart = rstart_q;
    assign bus.bk_waddr  = waddr_q;
    assign bus.bk_wdata  = wdata_q;
    assign bus.bk_wstrb  = wstrb_q;
    assign bus.bk_raddr  = raddr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
`ifdef AXIL_CMD_WRESP_EN
    assign bus.rsp_wr    = rsp_wr_q;
`else
    assign bus.rsp_wr    = 1'b0;
`endif
    assign busy          = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        cur_wr_d    = cur_wr_q;
        wstart_d    = 1'b0;
        rstart_d    = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        raddr_d     = raddr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
`ifdef AXIL_CMD_WRESP_EN
        rsp_wr_d    = rsp_wr_q;
`endif
        unique case (state_q)
            // Start pulse and backend fields are registered here so they appear during ISSUE.
            IDLE: begin
                if (!fifo_empty) begin
                    state_d  = ISSUE;
                    cur_wr_d = fifo_head.wr;
                    if (fifo_head.wr) begin
                        wstart_d = 1'b1;
                        waddr_d  = fifo_head.addr;
                        wdata_d  = fifo_head.data;
                        wstrb_d  = fifo_head.strb;
                    end else begin
                        rstart_d = 1'b1;
                        raddr_d  = fifo_head.addr;
                    end
                end
            end
            ISSUE: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (cur_wr_q && bus.bk_wdone) begin
`ifdef AXIL_CMD_WRESP_EN
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_wr_d    = 1'b1;
`else
                    state_d     = IDLE;
`endif
                end else if (!cur_wr_q && bus.bk_rdone) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.bk_rdata;
`ifdef AXIL_CMD_WRESP_EN
                    rsp_wr_d    = 1'b0;
`endif
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= IDLE;
            cur_wr_q    <= 1'b0;
            wstart_q    <= 1'b0;
            rstart_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            raddr_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef AXIL_CMD_WRESP_EN
            rsp_wr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_wr_q    <= cur_wr_d;
            wstart_q    <= wstart_d;
            rstart_q    <= rstart_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            raddr_q     <= raddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef AXIL_CMD_WRESP_EN
            rsp_wr_q    <= rsp_wr_d;
`endif
        end
    end

endmodule

// File: tb/tb_axilite_cmd_sequencer.sv
// Directed bench for axilite_cmd_sequencer with a behavioural backend master and
// command/response scoreboards. Honours AXIL_CMD_WRESP_EN when defined.
module tb_axilite_cmd_sequencer;
    import axilite_cmd_pkg::*;

    localparam int CMD_DEPTH = 4;
    localparam int CNT_W     = $clog2(CMD_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] cmd_count;

    axilite_cmd_sequencer_if bus();

    axilite_cmd_sequencer #(.CMD_DEPTH(CMD_DEPTH)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .bus         (bus),
        .busy        (busy),
        .cmd_count   (cmd_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] rdata;
    } exp_cmd_t;

    typedef struct {
        logic        wr;
        logic [31:0] data;
    } exp_rsp_t;

    exp_cmd_t    cmd_q[$];
    exp_rsp_t    rsp_q[$];
    int          n_assert = 0;
    int          n_fail = 0;

    bit          auto_done = 1'b1;
    int          done_dly = 3;
    bit          fire_req = 1'b0;
    bit          bogus_rdone = 1'b0;
    bit          pend = 1'b0;
    bit          pend_wr = 1'b0;
    logic [31:0] pend_rdata = '0;
    int          pend_cnt = 0;
    bit          hold_vld = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_wr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: response scoreboard on entry (values the next edge will see),
    // then at the falling edge the start scoreboard and the backend master model.
    task automatic tick();
        exp_rsp_t r;
        exp_cmd_t c;
        if (bus.rsp_valid) begin
            if (hold_vld) begin
                chk("rsp_data_stable", 64'(bus.rsp_data), 64'(hold_data));
                chk("rsp_wr_stable", 64'(bus.rsp_wr), 64'(hold_wr));
            end
            if (bus.rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_data", 64'(bus.rsp_data), 64'(r.data));
                    chk("rsp_wr", 64'(bus.rsp_wr), 64'(r.wr));
                end
                hold_vld = 1'b0;
            end else begin
                hold_vld  = 1'b1;
                hold_data = bus.rsp_data;
                hold_wr   = bus.rsp_wr;
            end
        end else begin
            hold_vld = 1'b0;
        end

        @(negedge clk);
        bus.bk_wdone = 1'b0;
        bus.bk_rdone = 1'b0;
        if (bus.bk_wstart || bus.bk_rstart) begin
            chk("start_overlap", 64'(bus.bk_wstart & bus.bk_rstart), 64'(0));
            if (cmd_q.size() == 0) begin
                chk("start_unexpected", 64'(1), 64'(0));
            end else begin
                c = cmd_q.pop_front();
                chk("start_kind", 64'(bus.bk_wstart), 64'(c.wr));
                if (c.wr) begin
                    chk("bk_waddr", 64'(bus.bk_waddr), 64'(c.addr));
                    chk("bk_wdata", 64'(bus.bk_wdata), 64'(c.data));
                    chk("bk_wstrb", 64'(bus.bk_wstrb), 64'(c.strb));
                end else begin
                    chk("bk_raddr", 64'(bus.bk_raddr), 64'(c.addr));
                end
                pend       = 1'b1;
                pend_wr    = c.wr;
                pend_rdata = c.rdata;
                pend_cnt   = done_dly;
            end
        end else if (pend && (fire_req || (auto_done && pend_cnt <= 1))) begin
            if (pend_wr) begin
                bus.bk_wdone = 1'b1;
            end else begin
                bus.bk_rdone = 1'b1;
                bus.bk_rdata = pend_rdata;
            end
            pend = 1'b0;
        end else if (pend && auto_done) begin
            pend_cnt--;
        end
        if (bogus_rdone) begin
            bus.bk_rdone = 1'b1;
            bus.bk_rdata = 32'hBAD0_BAD0;
            bogus_rdone  = 1'b0;
        end
        fire_req = 1'b0;
    endtask

    task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [31:0] rdata);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        bus.cmd_strb  = strb;
        while (!bus.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            chk("push_timeout", 64'(0), 64'(1));
        end else begin
            cmd_q.push_back('{wr: wr, addr: addr, data: data, strb: strb, rdata: rdata});
            if (!wr) rsp_q.push_back('{wr: 1'b0, data: rdata});
`ifdef AXIL_CMD_WRESP_EN
            else rsp_q.push_back('{wr: 1'b1, data: 32'h0});
`endif
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || cmd_count != 0 || cmd_q.size() != 0 || rsp_q.size() != 0 || pend) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < 300), 64'(1));
    endtask

    task automatic wait_pend(input string tag);
        int n = 0;
        while (!pend && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 64'(pend), 64'(1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
        chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'(0));
        chk({tag, "_rsp_wr"}, 64'(bus.rsp_wr), 64'(0));
        chk({tag, "_starts"}, 64'({bus.bk_wstart, bus.bk_rstart}), 64'(0));
        chk({tag, "_bk_fields"}, 64'({bus.bk_waddr, bus.bk_raddr}), 64'(0));
        chk({tag, "_bk_wdata"}, 64'({bus.bk_wdata, bus.bk_wstrb}), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_count"}, 64'(cmd_count), 64'(0));
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b1;
        bus.bk_wdone  = 1'b0;
        bus.bk_rdone  = 1'b0;
        bus.bk_rdata  = '0;

        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 64'(bus.cmd_ready), 64'(1));

        // Single write, done three cycles after the start pulse
        auto_done = 1'b1;
        done_dly  = 3;
        push_cmd(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'h0);
        wait_idle("write_done");
        chk("busy_after_write", 64'(busy), 64'(0));
        chk("waddr_holds", 64'(bus.bk_waddr), 64'(32'h0000_1000));

        // Single read
        push_cmd(1'b0, 32'h0000_2004, 32'h0, 4'h0, 32'h1234_5678);
        wait_idle("read_done");
        chk("raddr_holds", 64'(bus.bk_raddr), 64'(32'h0000_2004));

        // Five back-to-back commands with the backend stalled
        auto_done = 1'b0;
        push_cmd(1'b1, 32'h0000_0100, 32'h1111_1111, 4'h1, 32'h0);
        push_cmd(1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'hA0A0_A0A0);
        push_cmd(1'b1, 32'h0000_0108, 32'h3333_3333, 4'h3, 32'h0);
        push_cmd(1'b0, 32'h0000_010C, 32'h0, 4'h0, 32'h0F0F_0F0F);
        push_cmd(1'b1, 32'h0000_0110, 32'h5555_5555, 4'hC, 32'h0);
        chk("full_count", 64'(cmd_count), 64'(4));
        chk("full_ready", 64'(bus.cmd_ready), 64'(0));
        chk("full_one_in_flight", 64'(pend), 64'(1));
        auto_done = 1'b1;
        done_dly  = 1;
        wait_idle("burst_drain");

        // Read response back-pressured for ten cycles with a write queued behind it
        done_dly      = 2;
        bus.rsp_ready = 1'b0;
        push_cmd(1'b0, 32'h0000_3000, 32'h0, 4'h0, 32'hCAFE_F00D);
        push_cmd(1'b1, 32'h0000_4000, 32'h4444_4444, 4'hF, 32'h0);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("rsp_arrives", 64'(bus.rsp_valid), 64'(1));
        for (int i = 0; i < 10; i++) begin
            chk("stall_rsp_valid", 64'(bus.rsp_valid), 64'(1));
            chk("stall_rsp_data", 64'(bus.rsp_data), 64'(32'hCAFE_F00D));
            chk("stall_no_start", 64'({bus.bk_wstart, bus.bk_rstart}), 64'(0));
            chk("stall_queued", 64'(cmd_count), 64'(1));
            tick();
        end
        bus.rsp_ready = 1'b1;
        wait_idle("stall_drain");

        // Read-done of the wrong kind while a write is outstanding
        auto_done = 1'b0;
        push_cmd(1'b1, 32'h0000_5000, 32'h55AA_55AA, 4'hF, 32'h0);
        wait_pend("wrong_done_started");
        bogus_rdone = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrong_done_busy", 64'(busy), 64'(1));
            chk("wrong_done_no_rsp", 64'(bus.rsp_valid), 64'(0));
        end
        fire_req = 1'b1;
        wait_idle("wrong_done_drain");

        // Reset while waiting on the backend with two commands queued
        push_cmd(1'b1, 32'h0000_6000, 32'h6666_6666, 4'hF, 32'h0);
        push_cmd(1'b0, 32'h0000_7000, 32'h0, 4'h0, 32'h7777_7777);
        push_cmd(1'b1, 32'h0000_8000, 32'h8888_8888, 4'hF, 32'h0);
        wait_pend("reset_case_started");
        chk("reset_case_queued", 64'(cmd_count), 64'(2));
        chk("reset_case_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        cmd_q.delete();
        rsp_q.delete();
        pend     = 1'b0;
        hold_vld = 1'b0;
        repeat (2) tick();
        rst_n     = 1'b1;
        auto_done = 1'b1;
        repeat (15) tick();
        chk("post_reset_idle", 64'(busy), 64'(0));
        chk("post_reset_count", 64'(cmd_count), 64'(0));
        chk("post_reset_ready", 64'(bus.cmd_ready), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
